// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: word, opcode, memory-stage state and lane mask,
// plus opcode classification helpers used by the memory stage.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_mask;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'b00,
    MEM_ACC1 = 2'b01,
    MEM_ACC2 = 2'b10,
    MEM_DONE = 2'b11
  } lc3b_mem_state;

  function automatic logic is_mem_op(input lc3b_opcode op);
    case (op)
      op_ldr, op_ldb, op_ldi, op_str, op_stb, op_sti, op_trap: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_indirect(input lc3b_opcode op);
    case (op)
      op_ldi, op_sti: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Stores whose first access is already the write.
  function automatic logic is_direct_store(input lc3b_opcode op);
    case (op)
      op_str, op_stb: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane handling for the memory stage: STB data replication, write lane
// mask, and LDB byte selection with zero extension.
module mem_align
  import lc3b_types::*;
(
  input  lc3b_opcode   op_i,
  input  logic         addr_lsb_i,
  input  logic         write_en_i,
  input  lc3b_word     store_data_i,
  input  lc3b_word     rdata_i,
  output lc3b_word     wdata_o,
  output lc3b_mem_mask byte_en_o,
  output lc3b_word     load_word_o
);

  always_comb begin
    wdata_o     = 16'h0000;
    byte_en_o   = 2'b00;
    load_word_o = rdata_i;
    if (write_en_i) begin
      if (op_i == op_stb) begin
        wdata_o   = {store_data_i[7:0], store_data_i[7:0]};
        byte_en_o = addr_lsb_i ? 2'b10 : 2'b01;
      end else begin
        wdata_o   = store_data_i;
        byte_en_o = 2'b11;
      end
    end else begin
      wdata_o   = 16'h0000;
      byte_en_o = 2'b00;
    end
    if (op_i == op_ldb) begin
      load_word_o = {8'h00, (addr_lsb_i ? rdata_i[15:8] : rdata_i[7:0])};
    end else begin
      load_word_o = rdata_i;
    end
  end

endmodule

// File: rtl/mem_stage_access.sv
// LC-3b MEM-stage controller: turns the memory-class instruction in MEM into
// one or two data-memory transactions and stalls the pipeline until done.
module mem_stage_access
  import lc3b_types::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_in,
  input  lc3b_opcode   operation_in,
  input  lc3b_word     addr_in,
  input  lc3b_word     store_data_in,
  input  logic         stall_in,
  input  logic         mem_resp,
  input  lc3b_word     mem_rdata,
  output logic         mem_read,
  output logic         mem_write,
  output lc3b_word     mem_address,
  output lc3b_word     mem_wdata,
  output lc3b_mem_mask mem_byte_enable,
  output lc3b_word     load_data_out,
  output logic         done,
  output logic         stall_pipeline
);

  lc3b_mem_state state_q;
  lc3b_word      data_q;
  lc3b_word      indirect_q;
  lc3b_word      align_load;

  mem_align u_align (
    .op_i         (operation_in),
    .addr_lsb_i   (addr_in[0]),
    .write_en_i   (mem_write),
    .store_data_i (store_data_in),
    .rdata_i      (mem_rdata),
    .wdata_o      (mem_wdata),
    .byte_en_o    (mem_byte_enable),
    .load_word_o  (align_load)
  );

  // Access sequencer; responses outside ACC1/ACC2 never reach a latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= MEM_IDLE;
      data_q     <= 16'h0000;
      indirect_q <= 16'h0000;
    end else begin
      case (state_q)
        MEM_IDLE: begin
          if (valid_in && is_mem_op(operation_in)) state_q <= MEM_ACC1;
        end
        MEM_ACC1: begin
          if (mem_resp) begin
            if (is_indirect(operation_in)) begin
              indirect_q <= mem_rdata;
              state_q    <= MEM_ACC2;
            end else begin
              if (!is_direct_store(operation_in)) data_q <= align_load;
              state_q <= MEM_DONE;
            end
          end
        end
        MEM_ACC2: begin
          if (mem_resp) begin
            if (operation_in == op_ldi) data_q <= mem_rdata;
            state_q <= MEM_DONE;
          end
        end
        MEM_DONE: begin
          if (!stall_in) state_q <= MEM_IDLE;
        end
        default: state_q <= MEM_IDLE;
      endcase
    end
  end

  // Requests decode from the state register so reset drops them at once.
  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = 16'h0000;
    stall_pipeline = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        stall_pipeline = valid_in && is_mem_op(operation_in) && !reset;
      end
      MEM_ACC1: begin
        mem_address    = addr_in;
        stall_pipeline = 1'b1;
        if (is_direct_store(operation_in)) begin
          mem_write = 1'b1;
        end else begin
          mem_read = 1'b1;
        end
      end
      MEM_ACC2: begin
        mem_address    = indirect_q;
        stall_pipeline = 1'b1;
        if (operation_in == op_sti) begin
          mem_write = 1'b1;
        end else if (operation_in == op_ldi) begin
          mem_read = 1'b1;
        end else begin
          mem_read = 1'b0;
        end
      end
      MEM_DONE: stall_pipeline = 1'b0;
      default:  stall_pipeline = 1'b0;
    endcase
  end

  assign done          = (state_q == MEM_DONE);
  assign load_data_out = data_q;

endmodule

// File: doc/mem_stage_access.md
# mem_stage_access

Memory-stage access controller for the pipelined LC-3b datapath. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register and turns the memory-class instruction currently in MEM into one or two data-memory transactions. It also holds the pipeline while those transactions are outstanding and presents the aligned load result for the regfile mux feeding MEM/WB.

## Interface
Parameters: none; all widths come from `lc3b_types`.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `valid_in` in 1: the EX/MEM slot holds a real instruction, not a bubble.
- `operation_in` in `lc3b_opcode`: opcode of the instruction in MEM.
- `addr_in` in `lc3b_word`: effective address (ALU result). For TRAP this is the vector address.
- `store_data_in` in `lc3b_word`: SR value for stores.
- `stall_in` in 1: stall requested by other pipeline sources.
- `mem_resp` in 1: data memory has completed the current request.
- `mem_rdata` in `lc3b_word`: data memory read data.
- `mem_read` out 1: data memory read request.
- `mem_write` out 1: data memory write request.
- `mem_address` out `lc3b_word`: data memory address.
- `mem_wdata` out `lc3b_word`: data memory write data.
- `mem_byte_enable` out 2: write lane mask; bit 1 is the high byte.
- `load_data_out` out `lc3b_word`: registered, aligned load or TRAP-vector result.
- `done` out 1: the access for the current instruction has completed.
- `stall_pipeline` out 1: hold all pipeline registers.

## Operation
**Memory ops.** LDR, LDB, LDI, STR, STB, STI and TRAP. Every other opcode, and any `valid_in=0`, passes through with no request and `stall_pipeline=0`.

**States.** IDLE, ACC1, ACC2, DONE. The state is held in an enumerated register.

- **IDLE**
  - No request is driven.
  - If `valid_in` is high and the opcode is a memory op: `stall_pipeline=1`, next state ACC1.
- **ACC1** (first access, to `mem_address = addr_in`)
  - LDR, LDI, STI, TRAP, LDB: `mem_read=1`.
  - STR, STB: `mem_write=1`.
  - `stall_pipeline=1`.
  - On `mem_resp`:
    - LDI/STI: latch `indirect_reg <= mem_rdata`, go to ACC2.
    - All others: latch the result into `data_reg`, go to DONE.
- **ACC2** (second access, to `mem_address = indirect_reg`)
  - LDI: `mem_read=1`. STI: `mem_write=1` with word lanes.
  - `stall_pipeline=1`.
  - On `mem_resp`: LDI latches `data_reg <= mem_rdata`; go to DONE.
- **DONE**
  - `done=1`, `stall_pipeline=0`.
  - Stay in DONE while `stall_in=1`, so the instruction is never re-issued. Go to IDLE once `stall_in=0`.

**Write data and lanes.**
- Word stores: `mem_wdata = store_data_in`, `mem_byte_enable = 2'b11`.
- STB: `mem_wdata = {store_data_in[7:0], store_data_in[7:0]}`, `mem_byte_enable = addr_in[0] ? 2'b10 : 2'b01`.
- `mem_byte_enable = 2'b00` whenever `mem_write=0`.

**Load data.**
- LDB: `data_reg = ZEXT(addr_in[0] ? mem_rdata[15:8] : mem_rdata[7:0])`.
- LDR, LDI, TRAP: full word.
- `load_data_out = data_reg`. It changes only when a response is latched.

**Request outputs.** `mem_read` and `mem_write` decode from the state register only, never from `mem_resp`. They are never both high.

## Timing
- **Reset.** While `reset=1`, all outputs are held at these values:

  | Output / register | Value during reset |
  |---|---|
  | state | IDLE |
  | `data_reg`, `indirect_reg` | 0 |
  | `mem_read`, `mem_write` | 0 |
  | `mem_byte_enable` | 2'b00 |
  | `mem_address`, `mem_wdata` | 0 |
  | `load_data_out` | 0 |
  | `done` | 0 |
  | `stall_pipeline` | 0 |

- **Reset mid-access.** Requests drop immediately (asynchronously) and any outstanding memory response is ignored.
- **Latency, single-access op.** 1 (IDLE) + N (ACC1 until `mem_resp`) + 1 (DONE). A zero-wait memory gives 3 cycles, of which 2 are stalled.
- **Latency, LDI/STI.** 1 + N1 + N2 + 1.
- **Back-to-back memory ops.** After DONE the pipeline advances. The next op is seen in IDLE on the following cycle.
- **Response timing.**
  - A `mem_resp` in IDLE or DONE is ignored.
  - In ACC1 or ACC2, `mem_resp` is sampled at the clock edge and the transition happens at that same edge.
- **Inputs during stall.** `addr_in`, `store_data_in` and `operation_in` are stable throughout, because this block holds EX/MEM via `stall_pipeline`.

## Structure
- **`lc3b_types` additions:**
  - `lc3b_mem_state` enum (IDLE, ACC1, ACC2, DONE).
  - `lc3b_mem_mask` (2-bit) type.
- **Sub-module `mem_align`** (combinational): STB write-data replication, byte-enable generation, and LDB byte extraction and zero-extension.
- The FSM and registers live in `mem_stage_access`.

## Test plan
- **LDR.** `addr_in=0x1000`, memory returns 0xBEEF after 2 wait cycles.
  - Expect `mem_read` for 3 cycles at 0x1000, then DONE with `load_data_out=0xBEEF`.
  - Expect `stall_pipeline` high for 4 cycles total.
- **STB odd address.** `addr_in=0x2001`, `store_data_in=0x12A5`.
  - Expect `mem_wdata=0xA5A5`, `mem_byte_enable=2'b10`, `mem_write=1`; `mem_read` stays 0.
- **LDB even address.** `mem_rdata=0x80F3` → `load_data_out=0x00F3`.
- **LDI.** `addr_in=0x3000`, memory holds [0x3000]=0x4000 and [0x4000]=0x5A5A.
  - Expect a read at 0x3000, then a read at 0x4000, then `load_data_out=0x5A5A`.
- **STI.** Same addresses with `store_data_in=0x1234`.
  - Expect a write to 0x4000 with data 0x1234 and mask 2'b11.
- **`stall_in` held in DONE.** Hold `stall_in=1` for 3 cycles during DONE.
  - Expect no new request and `done` high for 4 cycles.
- **Reset in ACC2.** Assert `reset` while in ACC2.
  - Expect `mem_read` and `mem_write` to drop in the same cycle, the state to be IDLE, and `load_data_out=0`.
